// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port synchronous VRAM (1-cycle registered
// read) between the VGA glyph fetch path and the CPU load/store port.
//
// VGA fetches win by default; a one-entry hold buffer keeps a VGA request that
// lost its cycle. A starvation counter forces a CPU slot once the CPU has been
// eligible but refused STARVE_LIMIT times in a row.
//
// Ports:
//   clk, clear          system clock (posedge), asynchronous active-low reset
//   vga_req/vga_addr    single-cycle fetch request and its word address
//   vga_data/vga_valid  fetched word, valid during the one-cycle pulse
//   vga_overrun         sticky flag: a VGA request was dropped
//   cpu_req/we/addr/wdata  level request, held stable until cpu_ack
//   cpu_rdata/cpu_ack   read data and one-cycle completion pulse
//   mem_addr/we/wdata   VRAM drive, combinational from the current grant
//   mem_rdata           VRAM read data, valid the cycle after the address

module vram_arbiter #(
    parameter int unsigned ADDR_W       = 16,
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic [DATA_W-1:0] vga_data,
    output logic              vga_valid,
    output logic              vga_overrun,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_limit
        $error("vram_arbiter: STARVE_LIMIT must be in 1..255");
    end

    localparam logic [7:0] StarveMax = 8'(STARVE_LIMIT);

    typedef enum logic {
        CIdle,
        CWait
    } cpu_state_t;

    typedef enum logic [1:0] {
        GntNone,
        GntVgaNew,
        GntVgaHold,
        GntCpu
    } grant_t;

    // State
    cpu_state_t        cpu_state_q, cpu_state_d;
    logic              hold_valid_q, hold_valid_d;
    logic [ADDR_W-1:0] hold_addr_q, hold_addr_d;
    logic [7:0]        starve_cnt_q, starve_cnt_d;
    logic [ADDR_W-1:0] last_addr_q, last_addr_d;
    logic              rd_vga_q, rd_vga_d;
    logic              rd_cpu_q, rd_cpu_d;
    logic [DATA_W-1:0] vga_data_q, vga_data_d;
    logic              vga_valid_q, vga_valid_d;
    logic              overrun_q, overrun_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic              cpu_ack_q, cpu_ack_d;

    // Per-cycle decode
    logic              cpu_eligible;
    logic              starved;
    grant_t            grant;
    logic [ADDR_W-1:0] addr_sel;

    assign cpu_eligible = (cpu_state_q == CIdle) && cpu_req;
    assign starved      = (starve_cnt_q == StarveMax);

    // Priority: forced CPU slot, held VGA, fresh VGA, opportunistic CPU.
    always_comb begin
        grant = GntNone;
        if (cpu_eligible && starved) begin
            grant = GntCpu;
        end else if (hold_valid_q) begin
            grant = GntVgaHold;
        end else if (vga_req) begin
            grant = GntVgaNew;
        end else if (cpu_eligible) begin
            grant = GntCpu;
        end
    end

    always_comb begin
        addr_sel = last_addr_q;
        unique case (grant)
            GntCpu:     addr_sel = cpu_addr;
            GntVgaHold: addr_sel = hold_addr_q;
            GntVgaNew:  addr_sel = vga_addr;
            default:    addr_sel = last_addr_q;
        endcase
    end

    // The memory port must be quiet while reset is asserted, even though the
    // grant decode is purely combinational from the inputs.
    assign mem_addr  = clear ? addr_sel : '0;
    assign mem_we    = clear && (grant == GntCpu) && cpu_we;
    assign mem_wdata = cpu_wdata;

    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_addr_d  = hold_addr_q;
        overrun_d    = overrun_q;
        starve_cnt_d = starve_cnt_q;
        cpu_state_d  = cpu_state_q;
        last_addr_d  = addr_sel;
        rd_vga_d     = (grant == GntVgaNew) || (grant == GntVgaHold);
        rd_cpu_d     = (grant == GntCpu) && !cpu_we;
        vga_valid_d  = rd_vga_q;
        vga_data_d   = rd_vga_q ? mem_rdata : vga_data_q;
        cpu_ack_d    = rd_cpu_q || ((grant == GntCpu) && cpu_we);
        cpu_rdata_d  = rd_cpu_q ? mem_rdata : cpu_rdata_q;

        // Hold buffer: a losing vga_req always lands here; if it was already
        // occupied the older entry is lost and the overrun flag latches.
        if (grant == GntCpu && vga_req) begin
            hold_valid_d = 1'b1;
            hold_addr_d  = vga_addr;
            if (hold_valid_q) begin
                overrun_d = 1'b1;
            end
        end else if (grant == GntVgaHold) begin
            hold_valid_d = vga_req;
            if (vga_req) begin
                hold_addr_d = vga_addr;
            end
        end

        if (grant == GntCpu) begin
            starve_cnt_d = '0;
        end else if (cpu_state_q == CIdle && !cpu_req) begin
            starve_cnt_d = '0;
        end else if (cpu_eligible && !starved) begin
            starve_cnt_d = starve_cnt_q + 8'd1;
        end

        // Leaving CWait on the registered ack gives the one-cycle bubble.
        unique case (cpu_state_q)
            CIdle:   if (grant == GntCpu) cpu_state_d = CWait;
            CWait:   if (cpu_ack_q) cpu_state_d = CIdle;
            default: cpu_state_d = CIdle;
        endcase
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            cpu_state_q  <= CIdle;
            hold_valid_q <= 1'b0;
            hold_addr_q  <= '0;
            starve_cnt_q <= '0;
            last_addr_q  <= '0;
            rd_vga_q     <= 1'b0;
            rd_cpu_q     <= 1'b0;
            vga_data_q   <= '0;
            vga_valid_q  <= 1'b0;
            overrun_q    <= 1'b0;
            cpu_rdata_q  <= '0;
            cpu_ack_q    <= 1'b0;
        end else begin
            cpu_state_q  <= cpu_state_d;
            hold_valid_q <= hold_valid_d;
            hold_addr_q  <= hold_addr_d;
            starve_cnt_q <= starve_cnt_d;
            last_addr_q  <= last_addr_d;
            rd_vga_q     <= rd_vga_d;
            rd_cpu_q     <= rd_cpu_d;
            vga_data_q   <= vga_data_d;
            vga_valid_q  <= vga_valid_d;
            overrun_q    <= overrun_d;
            cpu_rdata_q  <= cpu_rdata_d;
            cpu_ack_q    <= cpu_ack_d;
        end
    end

    assign vga_data    = vga_data_q;
    assign vga_valid   = vga_valid_q;
    assign vga_overrun = overrun_q;
    assign cpu_rdata   = cpu_rdata_q;
    assign cpu_ack     = cpu_ack_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: directed scenarios followed by a
// randomized run checked against a cycle-level behavioural model.

module tb_vram_arbiter;

    localparam int Limit = 8;

    logic        clk;
    logic        clear;
    logic        vga_req;
    logic [15:0] vga_addr;
    logic [15:0] vga_data;
    logic        vga_valid;
    logic        vga_overrun;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic [15:0] cpu_rdata;
    logic        cpu_ack;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    // VRAM fixture with a side port for preloading
    logic        pre_we;
    logic [7:0]  pre_addr;
    logic [15:0] pre_data;
    logic [15:0] vram [0:255];

    int nvec;
    int nfail;

    typedef struct {
        int          due;
        bit          vga;
        bit          rd;
        logic [15:0] d;
    } ev_t;

    vram_arbiter #(
        .ADDR_W       (16),
        .DATA_W       (16),
        .STARVE_LIMIT (Limit)
    ) dut (
        .clk         (clk),
        .clear       (clear),
        .vga_req     (vga_req),
        .vga_addr    (vga_addr),
        .vga_data    (vga_data),
        .vga_valid   (vga_valid),
        .vga_overrun (vga_overrun),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_rdata   (cpu_rdata),
        .cpu_ack     (cpu_ack),
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pre_we) vram[pre_addr] <= pre_data;
        else if (mem_we) vram[mem_addr[7:0]] <= mem_wdata;
        mem_rdata <= vram[mem_addr[7:0]];
    end

    function automatic logic [15:0] pat(input int unsigned a);
        return 16'((a * 32'h9E37) ^ 32'h5A5A);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        vga_req   = 1'b0;
        vga_addr  = 16'h0;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = 16'h0;
        cpu_wdata = 16'h0;
    endtask

    task automatic apply_reset();
        tick();
        clear = 1'b0;
        idle_inputs();
        tick();
        clear = 1'b1;
    endtask

    // Preload 0..31 with the pattern and 0x00FA with a known glyph word.
    task automatic load_vram();
        for (int i = 0; i < 33; i++) begin
            tick();
            pre_we   = 1'b1;
            pre_addr = (i == 32) ? 8'hFA : 8'(i);
            pre_data = (i == 32) ? 16'hE31C : pat(i);
        end
        tick();
        pre_we = 1'b0;
    endtask

    task automatic test_reset();
        clear = 1'b0;
        idle_inputs();
        for (int k = 0; k < 13; k++) begin
            tick();
            clear = (k >= 3);
            #4;
            nvec++;
            if ({vga_valid, cpu_ack, vga_overrun, mem_we} !== 4'b0) begin
                nfail++;
                $display("FAIL reset_flags k=%0d got valid=%b ack=%b ovr=%b we=%b want 0",
                         k, vga_valid, cpu_ack, vga_overrun, mem_we);
            end
            nvec++;
            if ({vga_data, cpu_rdata, mem_addr} !== 48'h0) begin
                nfail++;
                $display("FAIL reset_data k=%0d got vd=%h rd=%h ma=%h want 0",
                         k, vga_data, cpu_rdata, mem_addr);
            end
        end
    endtask

    task automatic test_lone_vga();
        apply_reset();
        for (int k = 0; k < 10; k++) begin
            tick();
            vga_req  = (k == 5);
            vga_addr = 16'h00FA;
            #4;
            if (k == 5) begin
                nvec++;
                if (mem_addr !== 16'h00FA || mem_we !== 1'b0) begin
                    nfail++;
                    $display("FAIL lone_mem got addr=%h we=%b want 00fa/0", mem_addr, mem_we);
                end
            end
            nvec++;
            if (vga_valid !== (k == 7)) begin
                nfail++;
                $display("FAIL lone_valid k=%0d got %b want %b", k, vga_valid, (k == 7));
            end
            if (k == 7) begin
                nvec++;
                if (vga_data !== 16'hE31C) begin
                    nfail++;
                    $display("FAIL lone_data got %h want e31c", vga_data);
                end
            end
        end
        vga_req = 1'b0;
    endtask

    task automatic test_cpu_write_read();
        apply_reset();
        for (int k = 0; k < 7; k++) begin
            tick();
            cpu_req   = (k <= 4);
            cpu_we    = (k <= 1);
            cpu_addr  = 16'h0010;
            cpu_wdata = 16'hA5A5;
            #4;
            nvec++;
            if (mem_we !== (k == 0)) begin
                nfail++;
                $display("FAIL cwr_mem_we k=%0d got %b want %b", k, mem_we, (k == 0));
            end
            if (k == 0 || k == 2) begin
                nvec++;
                if (mem_addr !== 16'h0010) begin
                    nfail++;
                    $display("FAIL cwr_mem_addr k=%0d got %h want 0010", k, mem_addr);
                end
            end
            if (k == 0) begin
                nvec++;
                if (mem_wdata !== 16'hA5A5) begin
                    nfail++;
                    $display("FAIL cwr_wdata got %h want a5a5", mem_wdata);
                end
            end
            nvec++;
            if (cpu_ack !== (k == 1 || k == 4)) begin
                nfail++;
                $display("FAIL cwr_ack k=%0d got %b want %b", k, cpu_ack, (k == 1 || k == 4));
            end
            if (k == 4) begin
                nvec++;
                if (cpu_rdata !== 16'hA5A5) begin
                    nfail++;
                    $display("FAIL cwr_rdata got %h want a5a5", cpu_rdata);
                end
            end
        end
        idle_inputs();
    endtask

    task automatic test_starvation();
        logic [15:0] exp_addr;
        apply_reset();
        for (int k = 0; k < 13; k++) begin
            tick();
            vga_req  = (k <= 8);
            vga_addr = 16'(16'h0040 + k);
            cpu_req  = (k <= 10);
            cpu_we   = 1'b0;
            cpu_addr = 16'h0005;
            #4;
            exp_addr = (k <= 7) ? 16'(16'h0040 + k) : (k == 8) ? 16'h0005 : 16'h0048;
            nvec++;
            if (mem_addr !== exp_addr) begin
                nfail++;
                $display("FAIL starve_addr k=%0d got %h want %h", k, mem_addr, exp_addr);
            end
            nvec++;
            if (vga_valid !== ((k >= 2 && k <= 9) || k == 11)) begin
                nfail++;
                $display("FAIL starve_valid k=%0d got %b", k, vga_valid);
            end
            nvec++;
            if (cpu_ack !== (k == 10)) begin
                nfail++;
                $display("FAIL starve_ack k=%0d got %b want %b", k, cpu_ack, (k == 10));
            end
            if (k == 10) begin
                nvec++;
                if (cpu_rdata !== pat(5)) begin
                    nfail++;
                    $display("FAIL starve_rdata got %h want %h", cpu_rdata, pat(5));
                end
            end
            if (k == 12) begin
                nvec++;
                if (vga_overrun !== 1'b0) begin
                    nfail++;
                    $display("FAIL starve_overrun got %b want 0", vga_overrun);
                end
            end
        end
        idle_inputs();
    endtask

    task automatic test_overrun();
        logic [15:0] exp_addr;
        bit          chk;
        apply_reset();
        for (int k = 0; k < 25; k++) begin
            tick();
            vga_req  = (k <= 20);
            vga_addr = 16'(16'h0080 + k);
            cpu_req  = (k <= 21);
            cpu_we   = 1'b0;
            cpu_addr = 16'h0006;
            #4;
            chk = 1'b1;
            case (k)
                8, 19:   exp_addr = 16'h0006;
                20:      exp_addr = 16'h0093;
                21, 22:  exp_addr = 16'h0094;
                default: chk = 1'b0;
            endcase
            if (chk) begin
                nvec++;
                if (mem_addr !== exp_addr) begin
                    nfail++;
                    $display("FAIL ovr_addr k=%0d got %h want %h", k, mem_addr, exp_addr);
                end
            end
            nvec++;
            if (vga_overrun !== (k >= 20)) begin
                nfail++;
                $display("FAIL ovr_flag k=%0d got %b want %b", k, vga_overrun, (k >= 20));
            end
            nvec++;
            if (vga_valid !== (k >= 2 && k <= 23 && k != 10 && k != 21)) begin
                nfail++;
                $display("FAIL ovr_valid k=%0d got %b", k, vga_valid);
            end
            nvec++;
            if (cpu_ack !== (k == 10 || k == 21)) begin
                nfail++;
                $display("FAIL ovr_ack k=%0d got %b", k, cpu_ack);
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_read();
        apply_reset();
        for (int k = 0; k < 7; k++) begin
            tick();
            vga_req  = (k == 0);
            vga_addr = 16'h0003;
            clear    = (k != 1);
            #4;
            nvec++;
            if (vga_valid !== 1'b0 || vga_data !== 16'h0) begin
                nfail++;
                $display("FAIL midrst_vga k=%0d got valid=%b data=%h want 0/0000",
                         k, vga_valid, vga_data);
            end
            if (k == 1) begin
                nvec++;
                if (mem_we !== 1'b0 || mem_addr !== 16'h0) begin
                    nfail++;
                    $display("FAIL midrst_mem got we=%b addr=%h want 0/0000", mem_we, mem_addr);
                end
            end
        end
        clear = 1'b1;
    endtask

    task automatic test_random();
        ev_t         evq[$];
        logic [15:0] hq[$];
        logic [15:0] mm [0:255];
        int          starve;
        int          free_cyc;
        logic [15:0] e_vdata, e_crdata, last_addr, gaddr, exp_addr;
        bit          e_ovr, e_vvalid, e_cack, ovr_set, exp_we;
        bit          a_active, a_done, in_rst, elig;
        int          g;

        tick();
        clear = 1'b0;
        idle_inputs();
        load_vram();
        clear = 1'b1;
        for (int i = 0; i < 256; i++) mm[i] = (i < 32) ? pat(i) : 16'h0;
        starve = 0; free_cyc = 0;
        e_vdata = 0; e_crdata = 0; last_addr = 0; e_ovr = 0;
        a_active = 0; a_done = 0;

        for (int c = 0; c < 3000; c++) begin
            tick();
            in_rst = ($urandom_range(499) == 0);
            if (in_rst) begin
                clear   = 1'b0;
                vga_req = 1'b0;
                cpu_req = 1'b0;
                a_active = 0;
                evq.delete();
                hq.delete();
                starve = 0; free_cyc = 0;
                e_vdata = 0; e_crdata = 0; last_addr = 0; e_ovr = 0;
            end else begin
                clear = 1'b1;
                if (a_done) a_active = 0;
                if (!a_active && $urandom_range(2) == 0) begin
                    a_active  = 1;
                    cpu_we    = 1'($urandom_range(1));
                    cpu_addr  = 16'($urandom_range(31));
                    cpu_wdata = 16'($urandom);
                end
                cpu_req  = a_active;
                vga_req  = ($urandom_range(2) == 0);
                vga_addr = 16'($urandom_range(31));
            end

            // Responses due this cycle
            e_vvalid = 0;
            e_cack   = 0;
            for (int i = evq.size() - 1; i >= 0; i--) begin
                if (evq[i].due == c) begin
                    if (evq[i].vga) begin
                        e_vvalid = 1;
                        e_vdata  = evq[i].d;
                    end else begin
                        e_cack = 1;
                        if (evq[i].rd) e_crdata = evq[i].d;
                    end
                    evq.delete(i);
                end
            end
            a_done = e_cack;

            // Arbitration for this cycle
            g = 0; gaddr = 16'h0; ovr_set = 0; elig = 0;
            if (!in_rst) begin
                elig = cpu_req && (c >= free_cyc);
                if (elig && starve == Limit) begin
                    g = 2;
                    if (vga_req) begin
                        if (hq.size() != 0) begin
                            hq.delete();
                            ovr_set = 1;
                        end
                        hq.push_back(vga_addr);
                    end
                end else if (hq.size() != 0) begin
                    g = 1;
                    gaddr = hq.pop_front();
                    if (vga_req) hq.push_back(vga_addr);
                end else if (vga_req) begin
                    g = 1;
                    gaddr = vga_addr;
                end else if (elig) begin
                    g = 2;
                end
                if (g == 2) gaddr = cpu_addr;
            end
            exp_addr = (g != 0) ? gaddr : last_addr;
            exp_we   = (g == 2) && cpu_we;

            #4;
            nvec++;
            if (mem_addr !== exp_addr) begin
                nfail++;
                $display("FAIL rand_mem_addr c=%0d got %h want %h", c, mem_addr, exp_addr);
            end
            nvec++;
            if (mem_we !== exp_we) begin
                nfail++;
                $display("FAIL rand_mem_we c=%0d got %b want %b", c, mem_we, exp_we);
            end
            if (exp_we) begin
                nvec++;
                if (mem_wdata !== cpu_wdata) begin
                    nfail++;
                    $display("FAIL rand_mem_wdata c=%0d got %h want %h", c, mem_wdata, cpu_wdata);
                end
            end
            nvec++;
            if (vga_valid !== e_vvalid) begin
                nfail++;
                $display("FAIL rand_vga_valid c=%0d got %b want %b", c, vga_valid, e_vvalid);
            end
            nvec++;
            if (vga_data !== e_vdata) begin
                nfail++;
                $display("FAIL rand_vga_data c=%0d got %h want %h", c, vga_data, e_vdata);
            end
            nvec++;
            if (cpu_ack !== e_cack) begin
                nfail++;
                $display("FAIL rand_cpu_ack c=%0d got %b want %b", c, cpu_ack, e_cack);
            end
            nvec++;
            if (cpu_rdata !== e_crdata) begin
                nfail++;
                $display("FAIL rand_cpu_rdata c=%0d got %h want %h", c, cpu_rdata, e_crdata);
            end
            nvec++;
            if (vga_overrun !== e_ovr) begin
                nfail++;
                $display("FAIL rand_overrun c=%0d got %b want %b", c, vga_overrun, e_ovr);
            end

            // Commit the cycle into the model
            if (!in_rst) begin
                if (ovr_set) e_ovr = 1;
                if (g != 0) last_addr = gaddr;
                if (g == 1) begin
                    evq.push_back('{due: c + 2, vga: 1'b1, rd: 1'b1, d: mm[gaddr[7:0]]});
                end
                if (g == 2) begin
                    starve = 0;
                    if (cpu_we) begin
                        mm[gaddr[7:0]] = cpu_wdata;
                        evq.push_back('{due: c + 1, vga: 1'b0, rd: 1'b0, d: 16'h0});
                        free_cyc = c + 2;
                    end else begin
                        evq.push_back('{due: c + 2, vga: 1'b0, rd: 1'b1, d: mm[gaddr[7:0]]});
                        free_cyc = c + 3;
                    end
                end else if (elig) begin
                    starve = (starve + 1 > Limit) ? Limit : starve + 1;
                end else if (!cpu_req && c >= free_cyc) begin
                    starve = 0;
                end
            end
        end
        clear = 1'b1;
        idle_inputs();
    endtask

    initial begin
        nvec     = 0;
        nfail    = 0;
        clear    = 1'b0;
        pre_we   = 1'b0;
        pre_addr = 8'h0;
        pre_data = 16'h0;
        idle_inputs();
        load_vram();
        test_reset();
        test_lone_vga();
        test_cpu_write_read();
        test_starvation();
        test_overrun();
        test_reset_mid_read();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares one single-port synchronous video RAM (1-cycle registered read) between the VGA glyph fetch path and the CPU load/store port.
- VGA fetches have priority. A starvation guard forces a CPU slot after STARVE_LIMIT lost cycles.
- Sits between the VGA address generator / bit generator, the CPU memory interface and the VRAM macro. Runs on the system clock.

Parameters:
- ADDR_W, 16, address width of VRAM and both requesters.
- DATA_W, 16, data width (one glyph word).
- STARVE_LIMIT, 8, consecutive lost arbitration cycles after which an eligible CPU request wins; must be 1..255.

Ports:
- clk  in  1  system clock; all logic on posedge.
- clear  in  1  asynchronous active-low reset.
- vga_req  in  1  single-cycle fetch request; vga_addr sampled the same cycle.
- vga_addr  in  ADDR_W  VGA fetch word address.
- vga_data  out  DATA_W  fetched glyph word; valid while vga_valid.
- vga_valid  out  1  one-cycle pulse, vga_data valid.
- vga_overrun  out  1  sticky: a VGA request was dropped.
- cpu_req  in  1  level request; held with addr/we/wdata stable until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  CPU word address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_rdata  out  DATA_W  CPU read data; valid while cpu_ack on a read.
- cpu_ack  out  1  one-cycle completion pulse.
- mem_addr  out  ADDR_W  VRAM address (combinational from the grant).
- mem_we  out  1  VRAM write enable (combinational).
- mem_wdata  out  DATA_W  VRAM write data (combinational).
- mem_rdata  in  DATA_W  VRAM read data, valid the cycle after the address.

Behaviour:
- Reset (clear=0, async): vga_data=0, vga_valid=0, vga_overrun=0, cpu_rdata=0, cpu_ack=0. Hold buffer empty, starve_cnt=0, CPU FSM in C_IDLE, in-flight pipeline flushed. mem_we=0 and mem_addr=0 while in reset.
- Reset mid-operation: any in-flight read is discarded. No valid or ack pulse is produced for it after reset releases.
- VGA hold buffer (depth 1):
  - A vga_req that is not granted in its cycle is stored as hold (addr).
  - If the hold is full and a new vga_req is neither granted nor storable, the newer request replaces the hold and vga_overrun is set.
  - vga_overrun stays set until reset.
- CPU FSM:
  - C_IDLE: CPU is eligible when cpu_req=1. On grant, go to C_WAIT.
  - C_WAIT: CPU is not eligible. On cpu_ack, go to C_IDLE. CPU becomes eligible again the cycle after the ack (mandatory one-cycle bubble).
- Grant priority, evaluated every cycle N:
  - 1) If CPU is eligible and starve_cnt==STARVE_LIMIT, grant CPU. A concurrent vga_req goes into hold (overrun rule applies).
  - 2) Otherwise, if the hold is valid, grant the held VGA request. A concurrent vga_req is stored into hold.
  - 3) Otherwise, if vga_req, grant it.
  - 4) Otherwise, if CPU is eligible, grant CPU.
  - 5) Otherwise, idle: mem_we=0, mem_addr holds the last value.
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) each cycle CPU is eligible and not granted.
  - Clears on a CPU grant, or whenever cpu_req=0 in C_IDLE.
- Memory drive in cycle N:
  - mem_addr = the granted address.
  - mem_we = 1 only for a CPU write grant.
  - mem_wdata = cpu_wdata.
- Latency from grant in cycle N:
  - VGA read: mem_rdata is valid in N+1 and registered into vga_data. vga_valid=1 in N+2.
  - CPU read: same timing; cpu_rdata is loaded and cpu_ack=1 in N+2.
  - CPU write: cpu_ack=1 in N+1.
- Data outputs hold their last value when valid/ack are low.
- Back-to-back VGA grants every cycle are supported, giving a vga_valid pulse every cycle.
- A CPU write and a VGA read to the same address in consecutive grants are serviced in grant order. The VRAM provides no read-during-write forwarding.

Test Plan:
- Reset then idle: clear=0 for 3 cycles, release → all outputs 0, mem_we=0, no pulses for 10 cycles.
- Lone VGA fetch: VRAM[0x00FA]=0xE31C, vga_req pulse with addr 0x00FA at cycle 5 → mem_addr=0x00FA at 5, vga_valid=1 with vga_data=0xE31C at cycle 7 only.
- CPU write then read: cpu_req with we=1, addr 0x0010, wdata 0xA5A5 → mem_we=1 in the grant cycle, ack the next cycle. After the bubble, a read of 0x0010 → cpu_ack with cpu_rdata=0xA5A5 two cycles after its grant.
- Starvation guard, STARVE_LIMIT=8: vga_req every cycle and cpu_req held → CPU granted on the 9th cycle after its request. The VGA request of that cycle is held and granted next cycle with valid one cycle late. No overrun.
- Overrun: hold full plus vga_req on a forced CPU cycle, with another vga_req arriving → vga_overrun=1 and stays 1; the newer address is the one fetched.
- Reset mid-read: grant a VGA read, assert clear in N+1 → no vga_valid after release, vga_data=0.
